store_write_buffer: RTL and testbench

//  FIFO of pending stores between computeCore's External_Mem* port and the single-port DataMemory (vectorStorage).

---
 rtl/store_write_buffer.sv | 117 +++++++++++
 tb/tb_store_write_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_write_buffer.sv
// Store write buffer between the core's external memory port and a single-port data memory.
// Stores queue here and retire while the port is free; loads take the port at once unless they hit a queued word.
`ifndef BIT_COUNT
`define BIT_COUNT 64
`endif

module store_write_buffer #(
  parameter int DEPTH     = 4,
  parameter int BIT_COUNT = `BIT_COUNT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   CoreMemEn,
  input  logic                   CoreMemWriteEn,
  input  logic [BIT_COUNT/8-1:0] CoreMemByteEn,
  input  logic [BIT_COUNT-1:0]   CoreMemAdr,
  input  logic [BIT_COUNT-1:0]   CoreMemWriteData,
  output logic [BIT_COUNT-1:0]   CoreMemReadData,
  output logic                   Stall,
  output logic                   Empty,
  output logic                   MemEn,
  output logic                   MemWriteEn,
  output logic [BIT_COUNT/8-1:0] MemByteEn,
  output logic [BIT_COUNT-1:0]   MemAdr,
  output logic [BIT_COUNT-1:0]   MemWriteData,
  input  logic [BIT_COUNT-1:0]   MemReadData
);

  localparam int PW  = $clog2(DEPTH);
  localparam int BW  = BIT_COUNT / 8;
  localparam int LSB = $clog2(BW);

  logic [BIT_COUNT-1:0] adr_q  [DEPTH];
  logic [BIT_COUNT-1:0] data_q [DEPTH];
  logic [BW-1:0]        be_q   [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic          is_load;
  logic          is_store;
  logic          full;
  logic          hit;
  logic          load_go;
  logic          drain;
  logic          enq;
  logic [PW-1:0] idx;

  assign is_load  = CoreMemEn & ~CoreMemWriteEn;
  assign is_store = CoreMemEn & CoreMemWriteEn;
  assign full     = (count == (PW+1)'(DEPTH));

  // Word-granular compare against every occupied slot, oldest first from head.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (((PW+1)'(i) < count) &&
          (adr_q[idx][BIT_COUNT-1:LSB] == CoreMemAdr[BIT_COUNT-1:LSB]))
        hit = 1'b1;
    end
  end

  assign load_go = is_load & ~hit;
  assign drain   = ~load_go & (count != '0);
  assign enq     = is_store & ~full;
  assign Stall   = (is_store & full) | (is_load & hit);
  assign Empty   = (count == '0);

  assign CoreMemReadData = MemReadData;

  always_comb begin
    MemEn        = 1'b0;
    MemWriteEn   = 1'b0;
    MemByteEn    = '0;
    MemAdr       = '0;
    MemWriteData = '0;
    if (load_go) begin
      MemEn  = 1'b1;
      MemAdr = CoreMemAdr;
    end else if (drain) begin
      MemEn        = 1'b1;
      MemWriteEn   = 1'b1;
      MemByteEn    = be_q[head];
      MemAdr       = adr_q[head];
      MemWriteData = data_q[head];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq)   tail <= tail + PW'(1);
      if (drain) head <= head + PW'(1);
      case ({enq, drain})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload carries no reset; occupancy is defined solely by head/count.
  always_ff @(posedge clk) begin
    if (enq) begin
      adr_q[tail]  <= CoreMemAdr;
      data_q[tail] <= CoreMemWriteData;
      be_q[tail]   <= CoreMemByteEn;
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Randomised bench for store_write_buffer: queue-level reference model plus a decoupled scoreboard monitor.
module tb_store_write_buffer;

  localparam int DEPTH = 4;
  localparam int BC    = 64;

  typedef struct {
    logic [63:0] adr;
    logic [63:0] data;
    logic [7:0]  be;
  } st_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          CoreMemEn, CoreMemWriteEn;
  logic [7:0]    CoreMemByteEn;
  logic [BC-1:0] CoreMemAdr, CoreMemWriteData, CoreMemReadData;
  logic          Stall, Empty, MemEn, MemWriteEn;
  logic [7:0]    MemByteEn;
  logic [BC-1:0] MemAdr, MemWriteData, MemReadData;

  int total = 0;
  int bad   = 0;

  st_t         pend[$];
  st_t         exp_st[$];
  logic [63:0] exp_ld_adr[$];
  logic [63:0] exp_ld_data[$];
  logic [63:0] dmem[32];
  logic [63:0] mdl_mem[32];

  always #5 clk = ~clk;

  store_write_buffer #(.DEPTH(DEPTH), .BIT_COUNT(BC)) dut (
    .clk(clk), .reset(reset),
    .CoreMemEn(CoreMemEn), .CoreMemWriteEn(CoreMemWriteEn), .CoreMemByteEn(CoreMemByteEn),
    .CoreMemAdr(CoreMemAdr), .CoreMemWriteData(CoreMemWriteData), .CoreMemReadData(CoreMemReadData),
    .Stall(Stall), .Empty(Empty),
    .MemEn(MemEn), .MemWriteEn(MemWriteEn), .MemByteEn(MemByteEn),
    .MemAdr(MemAdr), .MemWriteData(MemWriteData), .MemReadData(MemReadData)
  );

  function automatic logic [63:0] init_word(input int i);
    return 64'h9E37_79B9_7F4A_7C15 * 64'(i + 1);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw, input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Behavioural single-port data memory: combinational read, byte-enabled write on posedge.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) dmem[i] <= init_word(i);
    end else if (MemEn && MemWriteEn) begin
      dmem[MemAdr[7:3]] <= merge(dmem[MemAdr[7:3]], MemWriteData, MemByteEn);
    end
  end
  assign MemReadData = (MemEn && !MemWriteEn) ? dmem[MemAdr[7:3]] : 64'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %h want nothing", name, act);
  endtask

  task automatic model_reset();
    pend.delete();
    exp_st.delete();
    exp_ld_adr.delete();
    exp_ld_data.delete();
    for (int i = 0; i < 32; i++) mdl_mem[i] = init_word(i);
  endtask

  // One core cycle: drive after posedge, evaluate the reference model at negedge.
  task automatic cycle(input bit en, input bit we, input logic [63:0] adr,
                       input logic [63:0] data, input logic [7:0] be, output bit stalled);
    bit  hit, full, ld_go;
    st_t s;
    @(posedge clk); #1;
    CoreMemEn = en; CoreMemWriteEn = we; CoreMemAdr = adr;
    CoreMemWriteData = data; CoreMemByteEn = be;
    @(negedge clk);
    hit = 1'b0;
    foreach (pend[i]) if (pend[i].adr[63:3] == adr[63:3]) hit = 1'b1;
    full    = (pend.size() == DEPTH);
    stalled = en && (we ? full : hit);
    chk("stall", Stall, stalled);
    chk("empty", Empty, pend.size() == 0);
    ld_go = en && !we && !hit;
    if (ld_go) begin
      exp_ld_adr.push_back(adr);
      exp_ld_data.push_back(mdl_mem[adr[7:3]]);
    end
    if (!ld_go && pend.size() > 0) void'(pend.pop_front());
    if (en && we && !full) begin
      s = '{adr, data, be};
      pend.push_back(s);
      exp_st.push_back(s);
      mdl_mem[adr[7:3]] = merge(mdl_mem[adr[7:3]], data, be);
    end
  endtask

  // Core holds its request while stalled; returns the number of stalled cycles.
  task automatic issue(input bit we, input logic [63:0] adr, input logic [63:0] data,
                       input logic [7:0] be, output int nstall);
    bit st;
    nstall = 0;
    for (int k = 0; k < 16; k++) begin
      cycle(1'b1, we, adr, data, be, st);
      if (!st) return;
      nstall++;
    end
    fail("hold_timeout", adr);
  endtask

  task automatic idle(input int n);
    bit st;
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 64'h0, 64'h0, 8'h0, st);
  endtask

  // Scoreboard monitor: pops an expectation whenever the memory port is used.
  initial begin
    st_t s;
    logic [63:0] a, d;
    forever begin
      @(negedge clk); #1;
      if (MemEn && MemWriteEn) begin
        if (exp_st.size() == 0) fail("unexpected_write", MemAdr);
        else begin
          s = exp_st.pop_front();
          chk("wr_adr", MemAdr, s.adr);
          chk("wr_data", MemWriteData, s.data);
          chk("wr_be", {56'h0, MemByteEn}, {56'h0, s.be});
        end
      end else if (MemEn) begin
        if (exp_ld_adr.size() == 0) fail("unexpected_load", MemAdr);
        else begin
          a = exp_ld_adr.pop_front();
          d = exp_ld_data.pop_front();
          chk("rd_adr", MemAdr, a);
          chk("rd_data", CoreMemReadData, d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got stuck want finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int ns;
    int r;
    logic [63:0] adr;
    CoreMemEn = 0; CoreMemWriteEn = 0; CoreMemByteEn = 0;
    CoreMemAdr = 0; CoreMemWriteData = 0;
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_empty", Empty, 1);
    chk("rst_stall", Stall, 0);
    chk("rst_memen", MemEn, 0);
    chk("rst_memwe", MemWriteEn, 0);
    chk("rst_memadr", MemAdr, 0);
    chk("rst_membe", {56'h0, MemByteEn}, 64'h0);
    reset = 1'b0;

    // Drain in program order
    issue(1, 64'h00, 64'h1111_2222_3333_4444, 8'hFF, ns);
    issue(1, 64'h08, 64'h5555_6666_7777_8888, 8'hFF, ns);
    issue(1, 64'h10, 64'h9999_AAAA_BBBB_CCCC, 8'hFF, ns);
    idle(2);

    // Stores interleaved with non-matching loads
    for (int k = 0; k < 5; k++) begin
      issue(1, 64'h40 + 64'(8 * k), {$urandom, $urandom}, 8'hFF, ns);
      issue(0, 64'hC0 + 64'(8 * k), 64'h0, 8'h0, ns);
    end
    idle(3);

    // Load hitting a queued store's word
    issue(1, 64'h20, 64'hAB, 8'h01, ns);
    issue(0, 64'h24, 64'h0, 8'h0, ns);
    chk("hazard_stall_cycles", 64'(ns), 64'd1);
    chk("hazard_byte", {56'h0, CoreMemReadData[7:0]}, 64'hAB);
    idle(1);

    // Load to another word goes straight through
    issue(1, 64'h40, 64'hDEAD_BEEF_0000_0001, 8'hF0, ns);
    issue(0, 64'h80, 64'h0, 8'h0, ns);
    chk("nohazard_stall_cycles", 64'(ns), 64'd0);
    idle(2);

    // Pointer wrap
    for (int k = 0; k < 10; k++) begin
      issue(1, 64'(8 * (k % 16)), {$urandom, $urandom}, 8'($urandom_range(1, 255)), ns);
      idle(1);
    end

    // Reset with a store pending
    issue(1, 64'hC8, 64'hFEED_FACE_CAFE_0001, 8'hFF, ns);
    @(posedge clk); #1;
    CoreMemEn = 0; CoreMemWriteEn = 0;
    reset = 1'b1;
    #1;
    chk("midrst_empty", Empty, 1);
    chk("midrst_stall", Stall, 0);
    chk("midrst_memen", MemEn, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(3);

    // Random traffic over a small address window to provoke hazards
    for (int k = 0; k < 400; k++) begin
      r   = $urandom_range(0, 3);
      adr = 64'($urandom_range(0, 7) * 8 + $urandom_range(0, 7));
      if (r == 0) idle(1);
      else if (r == 1) issue(0, adr, 64'h0, 8'h0, ns);
      else issue(1, adr, {$urandom, $urandom}, 8'($urandom_range(0, 255)), ns);
    end
    idle(6);

    chk("stores_outstanding", 64'(exp_st.size()), 64'd0);
    chk("loads_outstanding", 64'(exp_ld_adr.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
